// File: rtl/hit_score_unit.sv
// ============================================================================
// hit_score_unit
// ----------------------------------------------------------------------------
// Collision checker and score keeper for the dino runner.
// On every rising edge of the game tick (while the game is running and no
// collision has been recorded yet), the unit snapshots the dino and the three
// danger slots, then tests one slot per clk cycle. A collision raises a sticky
// hit flag plus a single-cycle hit_pulse. The unit also keeps a 4-digit BCD
// running score and a best score.
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   game_tick      game tick level (from the slower game clock), sampled here
//   game_state     0 INIT, 1 START, 2 END, 3 RESET
//   dino_pos       dino bottom-edge y (y grows downward)
//   dino_behavior  0 sit, 1 stand
//   danger_posN    obstacle right-edge x for slot N
//   danger_typeN   0 low bird, 1 high bird, 2 small, 3 many, 4 big cactus,
//                  5..7 nothing
//   danger_enN     slot N valid
//   hit            sticky collision flag
//   hit_pulse      one-cycle pulse on the first detected collision
//   hit_slot       lowest-numbered slot that caused the hit, 0 if none
//   score_bcd      running score, 4 BCD digits
//   hi_score_bcd   best score, 4 BCD digits
//   overrun        sticky: a tick arrived while a check was still running
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a tick edge in START with no hit recorded
//   CHK1  | testing slot 1 from the snapshot
//   CHK2  | testing slot 2 from the snapshot
//   CHK3  | testing slot 3, committing hit/hit_pulse/hit_slot/hi score
//   DONE  | hit_pulse visible (if any); returns to IDLE
// ============================================================================
module hit_score_unit #(
    parameter int GROUND_Y     = 400,
    parameter int DINO_X       = 40,
    parameter int DINO_W       = 40,
    parameter int DINO_STAND_H = 43,
    parameter int DINO_SIT_H   = 26,
    parameter int LOW_BIRD_LO  = 10,
    parameter int HIGH_BIRD_LO = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_tick,
    input  logic [1:0]  game_state,
    input  logic [9:0]  dino_pos,
    input  logic        dino_behavior,
    input  logic [9:0]  danger_pos1,
    input  logic [9:0]  danger_pos2,
    input  logic [9:0]  danger_pos3,
    input  logic [2:0]  danger_type1,
    input  logic [2:0]  danger_type2,
    input  logic [2:0]  danger_type3,
    input  logic        danger_en1,
    input  logic        danger_en2,
    input  logic        danger_en3,
    output logic        hit,
    output logic        hit_pulse,
    output logic [1:0]  hit_slot,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_score_bcd,
    output logic        overrun
);

    localparam logic [1:0] GS_START = 2'd1;
    localparam logic [1:0] GS_RESET = 2'd3;

    localparam logic [9:0]  GROUND_Y10 = 10'(GROUND_Y);
    localparam logic [10:0] DX         = 11'(DINO_X);
    localparam logic [10:0] DW         = 11'(DINO_W);
    localparam logic [10:0] STAND_H    = 11'(DINO_STAND_H);
    localparam logic [10:0] SIT_H      = 11'(DINO_SIT_H);
    localparam logic [10:0] LOW_LO     = 11'(LOW_BIRD_LO);
    localparam logic [10:0] HIGH_LO    = 11'(HIGH_BIRD_LO);
    localparam logic [10:0] BIRD_H     = 11'd33;

    typedef enum logic [2:0] {
        IDLE,
        CHK1,
        CHK2,
        CHK3,
        DONE
    } state_t;

    state_t      state;

    logic        tick_cur;
    logic        tick_prev;
    logic        tick_edge;
    logic        run_ok;

    logic [9:0]  snap_dino_pos;
    logic        snap_dino_beh;
    logic [9:0]  snap_pos1;
    logic [9:0]  snap_pos2;
    logic [9:0]  snap_pos3;
    logic [2:0]  snap_type1;
    logic [2:0]  snap_type2;
    logic [2:0]  snap_type3;
    logic        snap_en1;
    logic        snap_en2;
    logic        snap_en3;

    logic        pending;
    logic [1:0]  first_slot;

    logic        sel_en;
    logic [2:0]  sel_type;
    logic [9:0]  sel_pos;
    logic [1:0]  sel_num;
    logic [10:0] jump_h;
    logic [10:0] dino_h;
    logic        chk_hit;
    logic        pend_final;
    logic [1:0]  slot_final;

    // ------------------------------------------------------------------------
    // Obstacle geometry and overlap test. All arithmetic is 11 bits wide and
    // only additions are used on the obstacle side, so nothing can underflow.
    // ------------------------------------------------------------------------
    function automatic logic slot_hit(
        input logic        en,
        input logic [2:0]  typ,
        input logic [9:0]  pos,
        input logic [10:0] jh,
        input logic [10:0] dh
    );
        logic [10:0] w;
        logic [10:0] ob_lo;
        logic [10:0] ob_hi;
        logic [10:0] p;
        logic        real_obj;
        logic        horiz;
        logic        vert;
        w        = 11'd0;
        ob_lo    = 11'd0;
        ob_hi    = 11'd0;
        real_obj = 1'b1;
        p        = {1'b0, pos};
        case (typ)
            3'd0: begin w = 11'd44; ob_lo = LOW_LO;  ob_hi = LOW_LO + BIRD_H;  end
            3'd1: begin w = 11'd44; ob_lo = HIGH_LO; ob_hi = HIGH_LO + BIRD_H; end
            3'd2: begin w = 11'd19; ob_hi = 11'd36; end
            3'd3: begin w = 11'd77; ob_hi = 11'd49; end
            3'd4: begin w = 11'd27; ob_hi = 11'd50; end
            default: real_obj = 1'b0;
        endcase
        horiz = (p > DX) && (p < DX + DW + w);
        vert  = (jh < ob_hi) && (ob_lo < jh + dh);
        return en && real_obj && horiz && vert;
    endfunction

    // BCD +1 with per-digit carry, holding at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign tick_edge = tick_cur & ~tick_prev;
    assign run_ok    = tick_edge && (game_state == GS_START) && !hit;

    // Slot currently under test, taken from the snapshot.
    always_comb begin
        sel_en   = 1'b0;
        sel_type = 3'd7;
        sel_pos  = 10'd0;
        sel_num  = 2'd0;
        case (state)
            CHK1: begin sel_en = snap_en1; sel_type = snap_type1; sel_pos = snap_pos1; sel_num = 2'd1; end
            CHK2: begin sel_en = snap_en2; sel_type = snap_type2; sel_pos = snap_pos2; sel_num = 2'd2; end
            CHK3: begin sel_en = snap_en3; sel_type = snap_type3; sel_pos = snap_pos3; sel_num = 2'd3; end
            default: ;
        endcase
    end

    // Jump height above ground; a dino at or below the ground line counts as 0.
    always_comb begin
        jump_h = 11'd0;
        if (snap_dino_pos < GROUND_Y10) begin
            jump_h = {1'b0, GROUND_Y10 - snap_dino_pos};
        end
        dino_h = snap_dino_beh ? STAND_H : SIT_H;
    end

    always_comb begin
        chk_hit    = slot_hit(sel_en, sel_type, sel_pos, jump_h, dino_h);
        pend_final = pending | chk_hit;
        slot_final = pending ? first_slot : sel_num;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tick_cur      <= 1'b0;
            tick_prev     <= 1'b0;
            snap_dino_pos <= 10'd0;
            snap_dino_beh <= 1'b0;
            snap_pos1     <= 10'd0;
            snap_pos2     <= 10'd0;
            snap_pos3     <= 10'd0;
            snap_type1    <= 3'd0;
            snap_type2    <= 3'd0;
            snap_type3    <= 3'd0;
            snap_en1      <= 1'b0;
            snap_en2      <= 1'b0;
            snap_en3      <= 1'b0;
            pending       <= 1'b0;
            first_slot    <= 2'd0;
            hit           <= 1'b0;
            hit_pulse     <= 1'b0;
            hit_slot      <= 2'd0;
            score_bcd     <= 16'h0000;
            hi_score_bcd  <= 16'h0000;
            overrun       <= 1'b0;
        end else begin
            tick_cur  <= game_tick;
            tick_prev <= tick_cur;
            hit_pulse <= 1'b0;

            if (game_state == GS_RESET) begin
                // Restart of a game: best score survives, everything else clears.
                state      <= IDLE;
                pending    <= 1'b0;
                first_slot <= 2'd0;
                hit        <= 1'b0;
                hit_slot   <= 2'd0;
                score_bcd  <= 16'h0000;
                overrun    <= 1'b0;
            end else begin
                if (run_ok) begin
                    score_bcd <= bcd_inc(score_bcd);
                end
                if (tick_edge && (state != IDLE)) begin
                    overrun <= 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (run_ok) begin
                            snap_dino_pos <= dino_pos;
                            snap_dino_beh <= dino_behavior;
                            snap_pos1     <= danger_pos1;
                            snap_pos2     <= danger_pos2;
                            snap_pos3     <= danger_pos3;
                            snap_type1    <= danger_type1;
                            snap_type2    <= danger_type2;
                            snap_type3    <= danger_type3;
                            snap_en1      <= danger_en1;
                            snap_en2      <= danger_en2;
                            snap_en3      <= danger_en3;
                            pending       <= 1'b0;
                            first_slot    <= 2'd0;
                            state         <= CHK1;
                        end
                    end
                    CHK1, CHK2: begin
                        if (chk_hit && !pending) begin
                            first_slot <= sel_num;
                        end
                        pending <= pend_final;
                        state   <= (state == CHK1) ? CHK2 : CHK3;
                    end
                    CHK3: begin
                        // Commit on the way into DONE so the pulse is visible
                        // during the DONE cycle itself.
                        pending <= pend_final;
                        if (pend_final && !hit) begin
                            hit       <= 1'b1;
                            hit_pulse <= 1'b1;
                            hit_slot  <= slot_final;
                            if (score_bcd > hi_score_bcd) begin
                                hi_score_bcd <= score_bcd;
                            end
                        end
                        state <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hit_score_unit.sv
module tb_hit_score_unit;

    logic        clk;
    logic        rst;
    logic        game_tick;
    logic [1:0]  game_state;
    logic [9:0]  dino_pos;
    logic        dino_behavior;
    logic [9:0]  danger_pos1, danger_pos2, danger_pos3;
    logic [2:0]  danger_type1, danger_type2, danger_type3;
    logic        danger_en1, danger_en2, danger_en3;
    logic        hit;
    logic        hit_pulse;
    logic [1:0]  hit_slot;
    logic [15:0] score_bcd;
    logic [15:0] hi_score_bcd;
    logic        overrun;

    hit_score_unit dut (
        .clk           (clk),
        .rst           (rst),
        .game_tick     (game_tick),
        .game_state    (game_state),
        .dino_pos      (dino_pos),
        .dino_behavior (dino_behavior),
        .danger_pos1   (danger_pos1),
        .danger_pos2   (danger_pos2),
        .danger_pos3   (danger_pos3),
        .danger_type1  (danger_type1),
        .danger_type2  (danger_type2),
        .danger_type3  (danger_type3),
        .danger_en1    (danger_en1),
        .danger_en2    (danger_en2),
        .danger_en3    (danger_en3),
        .hit           (hit),
        .hit_pulse     (hit_pulse),
        .hit_slot      (hit_slot),
        .score_bcd     (score_bcd),
        .hi_score_bcd  (hi_score_bcd),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  slot;
        logic [15:0] score;
        logic [15:0] hi;
        int          at_cyc;
    } exp_t;

    exp_t exp_q[$];

    // Reference state of the game, kept in plain decimal.
    int m_score = 0;
    int m_hi    = 0;
    bit m_hit   = 0;

    function automatic logic [15:0] to_bcd(input int d);
        return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every hit_pulse is matched against the oldest expected hit.
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && hit_pulse) begin
            chk("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_latency", cyc, e.at_cyc);
                chk("pulse_hit",      {31'd0, hit}, 32'd1);
                chk("pulse_hit_slot", {30'd0, hit_slot}, {30'd0, e.slot});
                chk("pulse_score",    {16'd0, score_bcd}, {16'd0, e.score});
                chk("pulse_hi_score", {16'd0, hi_score_bcd}, {16'd0, e.hi});
            end
        end
        prev_pulse <= hit_pulse;
    end

    // Issue 'edges' tick edges 2 clk apart. exp_slot is the hand-derived slot
    // that should hit (0 = none); it only produces a pulse if a check starts.
    task automatic tick_n(input int edges, input logic [1:0] exp_slot, input int gap);
        int   c0;
        bit   starts;
        exp_t e;
        @(negedge clk);
        c0     = cyc;
        starts = (game_state == 2'd1) && !m_hit;
        for (int k = 0; k < edges; k++) begin
            if (game_state == 2'd1 && !m_hit && m_score < 9999) m_score++;
        end
        if (starts && exp_slot != 2'd0) begin
            m_hit = 1;
            if (m_score > m_hi) m_hi = m_score;
            e.slot   = exp_slot;
            e.score  = to_bcd(m_score);
            e.hi     = to_bcd(m_hi);
            e.at_cyc = c0 + 5;
            exp_q.push_back(e);
        end
        for (int k = 0; k < edges; k++) begin
            if (k != 0) @(negedge clk);
            game_tick = 1'b1;
            @(negedge clk);
            game_tick = 1'b0;
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic fast_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            game_tick = 1'b1;
            if (game_state == 2'd1 && !m_hit && m_score < 9999) m_score++;
            @(negedge clk);
            game_tick = 1'b0;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_hit"},   {31'd0, hit}, {31'd0, m_hit});
        chk({tag, "_score"}, {16'd0, score_bcd}, {16'd0, to_bcd(m_score)});
    endtask

    task automatic reset_game();
        @(negedge clk);
        game_state = 2'd3;
        @(negedge clk);
        game_state = 2'd1;
        m_hit   = 0;
        m_score = 0;
        chk("rg_hit",      {31'd0, hit}, 32'd0);
        chk("rg_hit_slot", {30'd0, hit_slot}, 32'd0);
        chk("rg_score",    {16'd0, score_bcd}, 32'd0);
        chk("rg_overrun",  {31'd0, overrun}, 32'd0);
        chk("rg_hi_score", {16'd0, hi_score_bcd}, {16'd0, to_bcd(m_hi)});
    endtask

    task automatic clear_slots();
        danger_en1 = 0; danger_en2 = 0; danger_en3 = 0;
        danger_type1 = 3'd5; danger_type2 = 3'd5; danger_type3 = 3'd5;
        danger_pos1 = 10'd0; danger_pos2 = 10'd0; danger_pos3 = 10'd0;
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: cycle limit reached (cycle %0d)", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        game_tick = 1'b0;
        game_state = 2'd0;
        dino_pos = 10'd400;
        dino_behavior = 1'b1;
        clear_slots();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hit",       {31'd0, hit}, 32'd0);
        chk("rst_hit_pulse", {31'd0, hit_pulse}, 32'd0);
        chk("rst_hit_slot",  {30'd0, hit_slot}, 32'd0);
        chk("rst_score",     {16'd0, score_bcd}, 32'd0);
        chk("rst_hi_score",  {16'd0, hi_score_bcd}, 32'd0);
        chk("rst_overrun",   {31'd0, overrun}, 32'd0);

        // Grounded standing dino vs small cactus at x=60.
        game_state = 2'd1;
        danger_en1 = 1; danger_type1 = 3'd2; danger_pos1 = 10'd60;
        tick_n(1, 2'd1, 6);
        check_state("small_cactus");
        chk("small_cactus_slot", {30'd0, hit_slot}, 32'd1);
        // Already hit: no new pulse, score frozen.
        tick_n(1, 2'd1, 6);
        check_state("sticky");
        reset_game();

        // Jump height 40 clears the 36-high cactus.
        dino_pos = 10'd360;
        tick_n(1, 2'd0, 6);
        check_state("jump_clear");
        // Right-edge boundary: 99 is just past, 98 overlaps.
        dino_pos = 10'd400;
        danger_pos1 = 10'd99;
        tick_n(1, 2'd0, 6);
        check_state("pos99");
        danger_pos1 = 10'd98;
        tick_n(1, 2'd1, 6);
        check_state("pos98");
        reset_game();

        // High bird in slot 2: sitting ducks under it, standing hits it.
        clear_slots();
        danger_en2 = 1; danger_type2 = 3'd1; danger_pos2 = 10'd70;
        dino_behavior = 1'b0;
        tick_n(1, 2'd0, 6);
        check_state("bird_sit");
        dino_behavior = 1'b1;
        tick_n(1, 2'd2, 6);
        check_state("bird_stand");
        chk("bird_stand_slot", {30'd0, hit_slot}, 32'd2);
        reset_game();

        // END / INIT freeze score and start no checks even with a hitting slot.
        clear_slots();
        danger_en1 = 1; danger_type1 = 3'd2; danger_pos1 = 10'd60;
        game_state = 2'd2;
        tick_n(1, 2'd1, 6);
        check_state("end_state");
        game_state = 2'd0;
        tick_n(1, 2'd1, 6);
        check_state("init_state");
        game_state = 2'd1;

        // Type 5 in slot 1 and disabled cactus in slot 3: ten clean ticks.
        danger_type1 = 3'd5;
        danger_en3 = 0; danger_type3 = 3'd2; danger_pos3 = 10'd60;
        for (int i = 0; i < 10; i++) tick_n(1, 2'd0, 6);
        check_state("ten_ticks");
        chk("ten_ticks_bcd", {16'd0, score_bcd}, 32'h0010);
        chk("ten_ticks_overrun", {31'd0, overrun}, 32'd0);

        // Reach 0x0123 on the colliding tick.
        fast_ticks(112);
        check_state("to_122");
        danger_type1 = 3'd2;
        tick_n(1, 2'd1, 6);
        check_state("hit_123");
        chk("hi_123", {16'd0, hi_score_bcd}, 32'h0123);
        reset_game();

        // Lower score at the next hit leaves the best score alone.
        danger_en1 = 0;
        fast_ticks(49);
        danger_en1 = 1;
        tick_n(1, 2'd1, 6);
        check_state("hit_50");
        chk("hi_kept", {16'd0, hi_score_bcd}, 32'h0123);
        reset_game();

        // Slots 1 and 3 both hit; two edges 2 clk apart -> one check, overrun.
        danger_en3 = 1;
        tick_n(2, 2'd1, 6);
        check_state("double_tick");
        chk("double_tick_overrun", {31'd0, overrun}, 32'd1);
        chk("double_tick_slot", {30'd0, hit_slot}, 32'd1);
        reset_game();

        // Saturation at 9999.
        clear_slots();
        fast_ticks(9998);
        check_state("to_9998");
        chk("bcd_9998", {16'd0, score_bcd}, 32'h9998);
        fast_ticks(3);
        check_state("sat");
        chk("bcd_9999", {16'd0, score_bcd}, 32'h9999);

        repeat (4) @(negedge clk);
        chk("pending_expected_pulses", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
